// File: rtl/gf2m_pkg.sv
// Shared GF(2^163) constants, FSM state type and polynomial-basis reduction.
// Reduction polynomial f(x) = x^163 + x^7 + x^6 + x^3 + 1.
package gf2m_pkg;

  localparam int M      = 163;
  localparam int N_TAPS = 4;
  localparam int RED_TAPS [N_TAPS] = '{7, 6, 3, 0};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } msq_state_e;

  // Folds every term of degree >= M back using x^M = x^7 + x^6 + x^3 + 1,
  // walking from the top so that folded terms landing above M-1 are caught too.
  function automatic logic [M-1:0] reduce(input logic [2*M-2:0] p);
    logic [2*M-2:0] r;
    r = p;
    for (int i = 2*M-2; i >= M; i--) begin
      if (r[i]) begin
        r[i] = 1'b0;
        for (int t = 0; t < N_TAPS; t++) begin
          r[i-M+RED_TAPS[t]] = ~r[i-M+RED_TAPS[t]];
        end
      end
    end
    return r[M-1:0];
  endfunction

endpackage

// File: rtl/gf2m_square_chain.sv
// Combinational chain of S field squarings; y holds x^(2^i) for i=1..S,
// slice i-1 of width M. No state, no flow control.
module gf2m_square_chain #(
  parameter int M = gf2m_pkg::M,
  parameter int S = 2
) (
  input  logic [M-1:0]   x,
  output logic [S*M-1:0] y
);
  import gf2m_pkg::*;

  logic [M-1:0] stage [0:S];

  assign stage[0] = x;

  for (genvar i = 1; i <= S; i++) begin : g_sq
    logic [2*M-2:0] spread;

    // Squaring in characteristic 2 just interleaves zeros between the bits.
    always_comb begin
      spread = '0;
      for (int j = 0; j < M; j++) begin
        spread[2*j] = stage[i-1][j];
      end
    end

    assign stage[i]        = reduce(spread);
    assign y[(i-1)*M +: M] = stage[i];
  end

endmodule

// File: rtl/gf2m_multisquare.sv
// Iterated GF(2^M) squarer b = a^(2^k): done pulses ceil(k/S)+1 cycles after accept;
// start is ignored while busy. Optional GF2M_MSQ_BYPASS_EN exposes the final result a cycle early.
module gf2m_multisquare #(
  parameter int M     = gf2m_pkg::M,
  parameter int S     = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [M-1:0]     a_in,
  input  logic [CNT_W-1:0] k_in,
  output logic             busy,
  output logic             done,
  output logic [M-1:0]     b_out
`ifdef GF2M_MSQ_BYPASS_EN
  ,
  output logic [M-1:0]     b_bp,
  output logic             bp_valid
`endif
);
  import gf2m_pkg::*;

  localparam logic [CNT_W-1:0] S_C = CNT_W'(S);

  msq_state_e       state, state_nxt;
  logic [M-1:0]     acc;
  logic [CNT_W-1:0] rem;
  logic [CNT_W-1:0] n_step;
  logic [S*M-1:0]   chain_y;
  logic [M-1:0]     acc_sq;
  logic             last_run;
  logic             accept;

  gf2m_square_chain #(
    .M (M),
    .S (S)
  ) u_chain (
    .x (acc),
    .y (chain_y)
  );

  // rem is never zero in RUN, so n_step always picks a real tap.
  assign last_run = (rem <= S_C);
  assign n_step   = last_run ? rem : S_C;
  assign accept   = (state == IDLE) && start;

  always_comb begin
    acc_sq = chain_y[M-1:0];
    for (int i = 1; i <= S; i++) begin
      if (n_step == CNT_W'(i)) acc_sq = chain_y[(i-1)*M +: M];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (k_in == '0) ? DONE : RUN;
      RUN:     if (last_run) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
      rem <= '0;
    end else if (accept) begin
      acc <= a_in;
      rem <= k_in;
    end else if (state == RUN) begin
      acc <= acc_sq;
      rem <= rem - n_step;
    end
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign b_out = acc;

`ifdef GF2M_MSQ_BYPASS_EN
  assign b_bp     = acc_sq;
  assign bp_valid = (state == RUN) && last_run;
`endif

endmodule
